led_strip_scheduler: RTL and testbench

LED_STRIP_SCHEDULER -- requirements
Module: led_strip_scheduler

---
 rtl/led_strip_scheduler.sv | 100 ++++++++++
 tb/tb_led_strip_scheduler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_strip_scheduler.sv
// LED strip frame scheduler: reads NUM_LEDS GRB words from the pixel buffer and hands them to the serial encoder. The LED_STRIP_SCHEDULER_AUTO_REPEAT_EN macro makes frames loop until reset.
// Latency: at least 3 clocks per pixel (fetch, wait, present), followed by LATCH_CYCLES clocks of line-low gap.
// Backpressure: valid/ready handshake; a stalled word stays in PRESENT and no further buffer reads are issued.
module led_strip_scheduler #(
  parameter int NUM_LEDS     = 60,
  parameter int ADDR_WIDTH   = 10,
  parameter int LATCH_CYCLES = 2400
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  frame_start,
  output logic                  frame_busy,
  output logic                  frame_done,
  output logic [ADDR_WIDTH-1:0] buf_addr,
  output logic                  buf_rd_en,
  input  logic [23:0]           buf_rd_data,
  output logic [23:0]           pixel_data,
  output logic                  pixel_valid,
  input  logic                  pixel_ready,
  output logic                  latch_active
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, PRESENT, LATCH} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(NUM_LEDS - 1);
  localparam logic [15:0]           LATCH_LOAD = 16'(LATCH_CYCLES - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] index;
  logic [15:0]           latch_cnt;

  // The index register is the read address; it stops at LAST_IDX, so it never wraps.
  assign buf_addr = index;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      index        <= '0;
      latch_cnt    <= '0;
      frame_busy   <= 1'b0;
      frame_done   <= 1'b0;
      buf_rd_en    <= 1'b0;
      pixel_data   <= '0;
      pixel_valid  <= 1'b0;
      latch_active <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      buf_rd_en  <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            index      <= '0;
            frame_busy <= 1'b1;
            buf_rd_en  <= 1'b1;
            state      <= FETCH;
          end
        end
        FETCH: state <= WAIT;
        WAIT: begin
          pixel_data  <= buf_rd_data;
          pixel_valid <= 1'b1;
          state       <= PRESENT;
        end
        PRESENT: begin
          if (pixel_ready) begin
            pixel_valid <= 1'b0;
            if (index < LAST_IDX) begin
              index     <= index + ADDR_WIDTH'(1);
              buf_rd_en <= 1'b1;
              state     <= FETCH;
            end else begin
              latch_active <= 1'b1;
              latch_cnt    <= LATCH_LOAD;
              state        <= LATCH;
            end
          end
        end
        LATCH: begin
          // The counter counts down from LATCH_CYCLES-1 to 0, so the gap lasts exactly LATCH_CYCLES clocks.
          if (latch_cnt == 16'd0) begin
            latch_active <= 1'b0;
            frame_done   <= 1'b1;
`ifdef LED_STRIP_SCHEDULER_AUTO_REPEAT_EN
            index     <= '0;
            buf_rd_en <= 1'b1;
            state     <= FETCH;
`else
            frame_busy <= 1'b0;
            state      <= IDLE;
`endif
          end else begin
            latch_cnt <= latch_cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_strip_scheduler.sv
// Directed bench for led_strip_scheduler: a 3-pixel instance driven from a vector table and by corner-case sequences, plus a 1-pixel/1-clock-latch instance.
module tb_led_strip_scheduler;

  typedef struct {
    logic        start;
    logic        ready;
    logic        busy;
    logic        rd_en;
    logic [9:0]  addr;
    logic        valid;
    logic [23:0] data;
    logic        latch;
    logic        done;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        pixel_ready = 1'b0;
  logic        frame_busy, frame_done, buf_rd_en, pixel_valid, latch_active;
  logic [9:0]  buf_addr;
  logic [23:0] buf_rd_data, pixel_data;

  logic        s_start = 1'b0;
  logic        s_ready = 1'b1;
  logic        s_busy, s_done, s_rd_en, s_valid, s_latch;
  logic [9:0]  s_addr;
  logic [23:0] s_rd_data, s_data;

  int applied = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  led_strip_scheduler #(.NUM_LEDS(3), .ADDR_WIDTH(10), .LATCH_CYCLES(10)) u0 (
    .clock(clock), .reset_n(reset_n), .frame_start(frame_start),
    .frame_busy(frame_busy), .frame_done(frame_done), .buf_addr(buf_addr),
    .buf_rd_en(buf_rd_en), .buf_rd_data(buf_rd_data), .pixel_data(pixel_data),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .latch_active(latch_active)
  );

  led_strip_scheduler #(.NUM_LEDS(1), .ADDR_WIDTH(10), .LATCH_CYCLES(1)) u1 (
    .clock(clock), .reset_n(reset_n), .frame_start(s_start),
    .frame_busy(s_busy), .frame_done(s_done), .buf_addr(s_addr),
    .buf_rd_en(s_rd_en), .buf_rd_data(s_rd_data), .pixel_data(s_data),
    .pixel_valid(s_valid), .pixel_ready(s_ready), .latch_active(s_latch)
  );

  function automatic logic [23:0] pix(input logic [9:0] a);
    case (a)
      10'd0:   pix = 24'h00FF00;
      10'd1:   pix = 24'h0000FF;
      10'd2:   pix = 24'hFF0000;
      default: pix = 24'h000000;
    endcase
  endfunction

  // Pixel buffer model: the word appears one clock after the read strobe.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      buf_rd_data <= '0;
      s_rd_data   <= '0;
    end else begin
      if (buf_rd_en) buf_rd_data <= pix(buf_addr);
      if (s_rd_en)   s_rd_data   <= pix(s_addr);
    end
  end

  function automatic vec_t mkv(input logic st, input logic rd, input logic bz, input logic re,
                               input logic [9:0] a, input logic v, input logic [23:0] d,
                               input logic la, input logic dn);
    vec_t r;
    r.start = st; r.ready = rd; r.busy = bz; r.rd_en = re; r.addr = a;
    r.valid = v; r.data = d; r.latch = la; r.done = dn;
    return r;
  endfunction

  function automatic vec_t cur0();
    return mkv(frame_start, pixel_ready, frame_busy, buf_rd_en, buf_addr, pixel_valid, pixel_data, latch_active, frame_done);
  endfunction

  function automatic vec_t cur1();
    return mkv(s_start, s_ready, s_busy, s_rd_en, s_addr, s_valid, s_data, s_latch, s_done);
  endfunction

  // The address is compared only on a read strobe and the data only while it is valid.
  task automatic check(input string name, input vec_t e, input vec_t a);
    bit ok;
    ok = (a.busy === e.busy) && (a.rd_en === e.rd_en) && (!e.rd_en || a.addr === e.addr) &&
         (a.valid === e.valid) && (!e.valid || a.data === e.data) &&
         (a.latch === e.latch) && (a.done === e.done);
    applied++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got busy=%b rd_en=%b addr=%0d valid=%b data=%h latch=%b done=%b; want busy=%b rd_en=%b addr=%0d valid=%b data=%h latch=%b done=%b",
               name, a.busy, a.rd_en, a.addr, a.valid, a.data, a.latch, a.done,
               e.busy, e.rd_en, e.addr, e.valid, e.data, e.latch, e.done);
    end
  endtask

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] want);
    applied++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      step();
      if (frame_done) seen = 1'b1;
    end
    check_val(name, 64'(seen), 64'd1);
  endtask

  task automatic wait_fetch(input string name, input logic [9:0] a, input int budget);
    bit found;
    found = 1'b0;
    for (int c = 0; c < budget && !found; c++) begin
      if (buf_rd_en && buf_addr == a) found = 1'b1;
      else step();
    end
    check_val(name, 64'(found), 64'd1);
  endtask

  function automatic logic [63:0] out_pack();
    return 64'({frame_busy, frame_done, buf_addr, buf_rd_en, pixel_data, pixel_valid, latch_active});
  endfunction

  vec_t tbl[$];
  vec_t s_tbl[5];

  initial begin
    int dn;
    bit i1, i2;

    // Single-shot frame, NUM_LEDS=3, LATCH_CYCLES=10, ready tied high.
    tbl.push_back(mkv(1, 1, 1, 1, 10'd0, 0, 24'h0, 0, 0));
    tbl.push_back(mkv(0, 1, 1, 0, 10'd0, 0, 24'h0, 0, 0));
    tbl.push_back(mkv(0, 1, 1, 0, 10'd0, 1, 24'h00FF00, 0, 0));
    tbl.push_back(mkv(0, 1, 1, 1, 10'd1, 0, 24'h0, 0, 0));
    tbl.push_back(mkv(0, 1, 1, 0, 10'd1, 0, 24'h0, 0, 0));
    tbl.push_back(mkv(0, 1, 1, 0, 10'd1, 1, 24'h0000FF, 0, 0));
    tbl.push_back(mkv(0, 1, 1, 1, 10'd2, 0, 24'h0, 0, 0));
    tbl.push_back(mkv(0, 1, 1, 0, 10'd2, 0, 24'h0, 0, 0));
    tbl.push_back(mkv(0, 1, 1, 0, 10'd2, 1, 24'hFF0000, 0, 0));
    for (int k = 0; k < 10; k++) tbl.push_back(mkv(0, 1, 1, 0, 10'd0, 0, 24'h0, 1, 0));
    tbl.push_back(mkv(0, 1, 0, 0, 10'd0, 0, 24'h0, 0, 1));
    tbl.push_back(mkv(0, 1, 0, 0, 10'd0, 0, 24'h0, 0, 0));

    s_tbl[0] = mkv(0, 1, 1, 1, 10'd0, 0, 24'h0, 0, 0);
    s_tbl[1] = mkv(0, 1, 1, 0, 10'd0, 0, 24'h0, 0, 0);
    s_tbl[2] = mkv(0, 1, 1, 0, 10'd0, 1, 24'h00FF00, 0, 0);
    s_tbl[3] = mkv(0, 1, 1, 0, 10'd0, 0, 24'h0, 1, 0);
    s_tbl[4] = mkv(0, 1, 0, 0, 10'd0, 0, 24'h0, 0, 1);

    repeat (3) @(posedge clock);
    @(negedge clock);
    check_val("reset_outputs_u0", out_pack(), 64'd0);
    check_val("reset_outputs_u1", 64'({s_busy, s_done, s_addr, s_rd_en, s_data, s_valid, s_latch}), 64'd0);
    reset_n = 1'b1;

`ifdef LED_STRIP_SCHEDULER_AUTO_REPEAT_EN
    begin
      int times[$];
      bit drop;
      drop = 1'b0;
      pixel_ready = 1'b1;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      for (int c = 1; c < 120; c++) begin
        if (!frame_busy) drop = 1'b1;
        if (frame_done) times.push_back(c);
        step();
      end
      check_val("repeat_busy_never_drops", 64'(drop), 64'd0);
      check_val("repeat_done_count", 64'(times.size() >= 4), 64'd1);
      if (times.size() >= 4)
        for (int k = 1; k < 4; k++)
          check_val($sformatf("repeat_period_%0d", k), 64'(times[k] - times[k-1]), 64'd19);
    end
`else
    for (int i = 0; i < tbl.size(); i++) begin
      frame_start = tbl[i].start;
      pixel_ready = tbl[i].ready;
      step();
      check($sformatf("frame_vec%0d", i), tbl[i], cur0());
    end
    frame_start = 1'b0;

    // NUM_LEDS=1, LATCH_CYCLES=1: FETCH, WAIT, PRESENT, one latch clock, then the done pulse.
    s_start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      s_start = 1'b0;
      check($sformatf("single_led_vec%0d", k), s_tbl[k], cur1());
    end

    // Encoder stall on pixel 1 for 20 clocks.
    pixel_ready = 1'b1;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    wait_fetch("stall_reach_pixel1", 10'd1, 20);
    pixel_ready = 1'b0;
    step();
    step();
    for (int k = 0; k < 20; k++) begin
      check_val($sformatf("stall_hold_%0d", k), 64'({pixel_valid, buf_rd_en, pixel_data}), {38'd0, 1'b1, 1'b0, 24'h0000FF});
      step();
    end
    pixel_ready = 1'b1;
    wait_done("stall_frame_done", 40);
    check_val("stall_busy_after", 64'(frame_busy), 64'd0);

    // frame_start during PRESENT and LATCH must be ignored.
    dn = 0;
    i1 = 1'b0;
    i2 = 1'b0;
    for (int c = 0; c < 60; c++) begin
      frame_start = 1'b0;
      if (c == 0) frame_start = 1'b1;
      else if (pixel_valid && !i1) begin frame_start = 1'b1; i1 = 1'b1; end
      else if (latch_active && !i2) begin frame_start = 1'b1; i2 = 1'b1; end
      step();
      if (frame_done) dn++;
    end
    frame_start = 1'b0;
    check_val("ignore_injected", 64'({i1, i2}), 64'd3);
    check_val("ignore_done_count", 64'(dn), 64'd1);
    check_val("ignore_busy_after", 64'(frame_busy), 64'd0);

    // Reset while pixel 2 is in flight.
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    wait_fetch("reset_reach_pixel2", 10'd2, 20);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 check_val("reset_mid_frame_outputs", out_pack(), 64'd0);
    @(negedge clock);
    step();
    reset_n = 1'b1;
    dn = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (frame_done) dn++;
    end
    check_val("reset_no_done", 64'(dn), 64'd0);
    check_val("reset_idle_busy", 64'(frame_busy), 64'd0);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check_val("reset_restart_addr0", 64'({frame_busy, buf_rd_en, buf_addr}), {52'd0, 1'b1, 1'b1, 10'd0});
    wait_done("reset_restart_done", 40);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
